// File: rtl/button_event_scheduler.sv
// Serialises debounced button rises into one press event per clock, lowest index
// first, with hold-to-repeat on the most recently granted button.
module button_event_scheduler #(
    parameter int BUTTONS       = 4,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 3,
    parameter int REPEAT_ENABLE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [BUTTONS-1:0]         buttons,
    output logic                       event_pulse,
    output logic [$clog2(BUTTONS)-1:0] eventIndex,
    output logic                       eventRepeat,
    output logic                       held
);

    localparam int IDX_W   = $clog2(BUTTONS);
    localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t             state_r;
    logic [BUTTONS-1:0] prev_r;
    logic [BUTTONS-1:0] pend_r;
    logic [IDX_W-1:0]   active_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               event_r;
    logic [IDX_W-1:0]   event_index_r;
    logic               event_repeat_r;
    logic               held_r;

    logic [BUTTONS-1:0] rise_s;
    logic [BUTTONS-1:0] req_s;
    logic [BUTTONS-1:0] grant_onehot_s;
    logic               grant_valid_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_held_s;

    // Rise detection and lowest-index arbitration over queued and fresh presses
    always_comb begin
        rise_s         = buttons & ~prev_r;
        req_s          = pend_r | rise_s;
        grant_valid_s  = |req_s;
        grant_onehot_s = req_s & (~req_s + {{(BUTTONS-1){1'b0}}, 1'b1});
        grant_idx_s    = {IDX_W{1'b0}};
        for (int i = 0; i < BUTTONS; i++) begin
            grant_idx_s = grant_idx_s | (grant_onehot_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        // A queued tap that is already released is reported but never enters the hold states
        grant_held_s = (REPEAT_ENABLE != 0) && buttons[grant_idx_s];
    end

    // Previous levels and the pending-press queue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_r <= {BUTTONS{1'b0}};
            pend_r <= {BUTTONS{1'b0}};
        end else begin
            prev_r <= buttons;
            pend_r <= req_s & ~grant_onehot_s;
        end
    end

    // Press/repeat FSM with registered event outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            active_r       <= {IDX_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            event_r        <= 1'b0;
            event_index_r  <= {IDX_W{1'b0}};
            event_repeat_r <= 1'b0;
            held_r         <= 1'b0;
        end else begin
            event_r        <= 1'b0;
            event_repeat_r <= 1'b0;
            if (grant_valid_s) begin
                event_r       <= 1'b1;
                event_index_r <= grant_idx_s;
                active_r      <= grant_idx_s;
                cnt_r         <= CNT_W'(HOLD_CYCLES - 1);
                state_r       <= grant_held_s ? ST_DELAY : ST_IDLE;
                held_r        <= grant_held_s;
            end else begin
                case (state_r)
                    ST_DELAY, ST_REPEAT: begin
                        if (!buttons[active_r]) begin
                            state_r <= ST_IDLE;
                            held_r  <= 1'b0;
                        end else if (cnt_r == {CNT_W{1'b0}}) begin
                            event_r        <= 1'b1;
                            event_repeat_r <= 1'b1;
                            event_index_r  <= active_r;
                            cnt_r          <= CNT_W'(REPEAT_CYCLES - 1);
                            state_r        <= ST_REPEAT;
                            held_r         <= 1'b1;
                        end else begin
                            cnt_r  <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                            held_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        held_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign event_pulse = event_r;
    assign eventIndex  = event_index_r;
    assign eventRepeat = event_repeat_r;
    assign held        = held_r;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler: expected events are queued with
// their edge number and a negedge monitor pops and compares them.
module tb_button_event_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] buttons;
    logic       event_pulse;
    logic [1:0] eventIndex;
    logic       eventRepeat;
    logic       held;

    typedef struct {
        int cyc;
        int idx;
        int rep;
    } exp_t;

    exp_t q[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    int   n;

    button_event_scheduler #(
        .BUTTONS(4),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(3),
        .REPEAT_ENABLE(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .buttons(buttons),
        .event_pulse(event_pulse),
        .eventIndex(eventIndex),
        .eventRepeat(eventRepeat),
        .held(held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every observed event must match the head of the expectation queue
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && event_pulse) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: got edge=%0d idx=%0d rep=%0d, required no event",
                         cyc, eventIndex, eventRepeat);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.idx != int'(eventIndex) || e.rep != int'(eventRepeat)) begin
                    mismatched++;
                    $display("FAIL event: got edge=%0d idx=%0d rep=%0d, required edge=%0d idx=%0d rep=%0d",
                             cyc, eventIndex, eventRepeat, e.cyc, e.idx, e.rep);
                end
            end
        end
    end

    task automatic expect_ev(input int at, input int idx, input int rep);
        exp_t e;
        e.cyc = at;
        e.idx = idx;
        e.rep = rep;
        q.push_back(e);
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        reset   = 1'b1;
        buttons = 4'b0000;
        step(3);
        #1;
        check("reset_event", int'(event_pulse), 0);
        check("reset_index", int'(eventIndex), 0);
        check("reset_repeat", int'(eventRepeat), 0);
        check("reset_held", int'(held), 0);
        reset = 1'b0;
        step(2);

        // Single press, held two edges, no repeats
        n = cyc;
        buttons = 4'b0010;
        expect_ev(n + 1, 1, 0);
        step(2);
        check("single_held_while_pressed", int'(held), 1);
        buttons = 4'b0000;
        step(1);
        check("single_held_after_release", int'(held), 0);
        step(4);

        // Hold-to-repeat on button 2 for 20 sampling edges
        n = cyc;
        buttons = 4'b0100;
        expect_ev(n + 1, 2, 0);
        expect_ev(n + 9, 2, 1);
        expect_ev(n + 12, 2, 1);
        expect_ev(n + 15, 2, 1);
        expect_ev(n + 18, 2, 1);
        step(20);
        buttons = 4'b0000;
        step(5);
        check("repeat_held_after_release", int'(held), 0);

        // Simultaneous rises: 0, 1, 3 on consecutive edges, repeats follow 3
        n = cyc;
        buttons = 4'b1011;
        expect_ev(n + 1, 0, 0);
        expect_ev(n + 2, 1, 0);
        expect_ev(n + 3, 3, 0);
        expect_ev(n + 11, 3, 1);
        step(12);
        buttons = 4'b0000;
        step(5);

        // Preemption on the edge where button 0's first repeat is due
        n = cyc;
        buttons = 4'b0001;
        expect_ev(n + 1, 0, 0);
        step(8);
        buttons = 4'b0101;
        expect_ev(n + 9, 2, 0);
        expect_ev(n + 17, 2, 1);
        step(9);
        buttons = 4'b0000;
        step(5);

        // Short tap while queued: button 1 released before its grant
        n = cyc;
        buttons = 4'b0011;
        expect_ev(n + 1, 0, 0);
        expect_ev(n + 2, 1, 0);
        step(1);
        check("tap_held_first_grant", int'(held), 1);
        buttons = 4'b0001;
        step(1);
        check("tap_held_after_queued_grant", int'(held), 0);
        step(3);
        check("tap_no_repeat_held", int'(held), 0);
        buttons = 4'b0000;
        step(3);

        // Asynchronous reset while repeating, button kept held throughout
        n = cyc;
        buttons = 4'b0010;
        expect_ev(n + 1, 1, 0);
        expect_ev(n + 9, 1, 1);
        expect_ev(n + 12, 1, 1);
        step(12);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_event", int'(event_pulse), 0);
        check("async_reset_index", int'(eventIndex), 0);
        check("async_reset_repeat", int'(eventRepeat), 0);
        check("async_reset_held", int'(held), 0);
        step(2);
        reset = 1'b0;
        n = cyc;
        expect_ev(n + 1, 1, 0);
        step(1);
        check("post_reset_held", int'(held), 1);
        step(2);
        buttons = 4'b0000;
        step(6);

        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_event_scheduler.md
# button_event_scheduler

Turns a vector of debounced button levels into a single serialized stream of press events, one event per clock at most, with hold-to-repeat. Sits between the per-button debouncers and the seven-segment control logic. The control logic consumes one press at a time from a single index, regardless of how many buttons change together. The block replaces per-button edge detectors with one shared, arbitrated edge/repeat scheduler.

## Interface
- BUTTONS, 4: number of button inputs; legal range 2..16.
- HOLD_CYCLES, 8: clocks from the grant of a press to its first repeat event; must be >= 1.
- REPEAT_CYCLES, 3: clocks between subsequent repeat events; must be >= 1.
- REPEAT_ENABLE, 1: 0 disables all repeat events; the block then is a pure press arbiter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- buttons  input  BUTTONS  debounced button levels, synchronous to clock; 1 = pressed.
- event  output  1  one-cycle pulse: a press or repeat is reported this cycle.
- eventIndex  output  $clog2(BUTTONS)  button index of the current event; holds its last value when event = 0.
- eventRepeat  output  1  qualifies event: 1 = repeat, 0 = new press.
- held  output  1  high while the FSM is in DELAY or REPEAT, i.e. the active button is still held.

## Operation
- Per-button previous-level register prev[i].
  - rise[i] = buttons[i] & ~prev[i].
  - prev <= buttons every clock.
- Pending register pend[i]:
  - Set on rise[i].
  - Cleared when button i is granted.
  - A press is never lost, even if the button is released before its grant.
- Press request vector = pend | rise.
  - Grant goes to the lowest set index.
  - At most one grant per clock.
  - Ungranted requests stay in pend and are served on the following clocks in ascending index order.
- FSM states:
  - IDLE: no active button.
  - DELAY: waiting for the first repeat of the active button.
  - REPEAT: periodic repeats of the active button.
- Register active holds the index of the last granted press.
- Counter cnt has width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
- Transitions, evaluated in priority order each edge:
  1. Press grant for index g (any state): event=1, eventRepeat=0, eventIndex=g, active<=g, cnt<=HOLD_CYCLES-1. Next state is DELAY if REPEAT_ENABLE, else IDLE.
  2. In DELAY or REPEAT with buttons[active]=0: next state IDLE, no event.
  3. In DELAY or REPEAT with cnt=0: event=1, eventRepeat=1, eventIndex=active, cnt<=REPEAT_CYCLES-1, next state REPEAT.
  4. In DELAY or REPEAT otherwise: cnt<=cnt-1.
- A new press preempts and replaces the active button. The old button stops repeating even if it is still held.
- If a press grant coincides with cnt=0, the repeat is not emitted. The new press's hold timing starts fresh.
- If a release coincides with cnt=0, the release wins and no event is emitted.
- Reset, asynchronous, at any point including mid-repeat:
  - prev=0, pend=0, cnt=0, active=0, state IDLE.
  - event=0, eventIndex=0, eventRepeat=0, held=0.
- Because prev resets to 0, a button held through reset deassertion is reported as a press on the first clock edge.

## Timing
- All outputs are registered.
- Press latency: buttons[i] first sampled high at edge E gives event high for the cycle following E. The pulse is exactly one cycle wide unless another event follows back to back.
- First repeat is at edge E+HOLD_CYCLES. Later repeats are every REPEAT_CYCLES edges while the button stays held and no other press is granted.
- N simultaneous rises produce N press events on N consecutive edges, lowest index first. A queued press's hold timing starts at its own grant edge.
- Throughput: one event per clock maximum. Back-to-back events are legal, so event may remain high across cycles with a changing eventIndex.
- held follows the FSM state with the same one-edge latency as event.

## Test plan
- Reset then single press: hold buttons=4'b0010 for 2 cycles, then release. Required: one event, eventIndex=1, eventRepeat=0, one cycle after the first sampling edge. No repeats. held falls the edge after release is sampled.
- Hold-to-repeat (HOLD=8, REPEAT=3): hold buttons[2] for 20 cycles from edge 0. Required: press at edge 0, repeats at edges 8, 11, 14, 17, then none after release.
- Simultaneous press: buttons 0->4'b1011 in one cycle. Required: events with index 0, 1, 3 on three consecutive edges, all eventRepeat=0. The repeat schedule follows button 3, the last granted, with its first repeat 8 edges after its own grant.
- Preemption plus coincidence: hold button 0, then press button 2 exactly on the edge where button 0's first repeat is due. Required: press event index 2 only. Button 0 never repeats. Button 2's repeat comes 8 edges later.
- Short tap while queued: rise on buttons 0 and 1 together, with button 1 released the next cycle. Required: index 1 is still reported on the second edge, and held=0 after that edge.
- Async reset mid-REPEAT: assert reset between edges while repeating. Required: all outputs 0 immediately. After release with the button still held, one press event is reported at the first edge.
